rr_stats: RTL and testbench

RR_STATS -- requirements
Module: rr_stats

---
 rtl/rr_stats.sv | 201 ++++++++++++++++++++
 tb/tb_rr_stats.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stats.sv
// rr_stats: windowed RR-interval averaging and heart-rate computation.
// Accepted beats go into an N_AVG-entry ring whose running sum gives the mean RR.
// A 16-cycle restoring divider then turns 60*FS_HZ / mean into beats per minute.
// Optional feature: define RR_STATS_MINMAX_EN to track the min/max accepted RR.
// Without it, o_rr_min/o_rr_max are tied to zero.
module rr_stats #(
   parameter int DATA_WIDTH = 11,
   parameter int FS_HZ      = 360,
   parameter int N_AVG      = 8,
   parameter int RR_MIN     = 72,
   parameter int RR_MAX     = 720
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_ce,
   input  logic [DATA_WIDTH-1:0] i_rr_period,
   input  logic                  i_rr_valid,
   output logic                  o_busy,
   output logic [DATA_WIDTH-1:0] o_rr_avg,
   output logic [7:0]            o_hr_bpm,
   output logic                  o_hr_valid,
   input  logic                  i_hr_ready,
   output logic                  o_artifact,
   output logic                  o_overrun,
   output logic [DATA_WIDTH-1:0] o_rr_min,
   output logic [DATA_WIDTH-1:0] o_rr_max
);

   localparam int LOG2N = $clog2(N_AVG);
   localparam int SUM_W = DATA_WIDTH + LOG2N;
   localparam logic [15:0]           NUMER = 16'(60 * FS_HZ);
   localparam logic [DATA_WIDTH-1:0] RR_LO = DATA_WIDTH'(RR_MIN);
   localparam logic [DATA_WIDTH-1:0] RR_HI = DATA_WIDTH'(RR_MAX);

   typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, OUTPUT} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] ring_q [N_AVG];
   logic [DATA_WIDTH-1:0] ring_d [N_AVG];
   logic [SUM_W-1:0]      sum_q, sum_d;
   logic [LOG2N-1:0]      wptr_q, wptr_d;
   logic                  first_q, first_d;
   logic [DATA_WIDTH-1:0] rr_q, rr_d;
   logic [DATA_WIDTH-1:0] avg_q, avg_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [15:0]           quo_q, quo_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [7:0]            bpm_q, bpm_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;
   logic                  art_q, art_d;
   logic [DATA_WIDTH:0]   rem_sh;
   logic [DATA_WIDTH-1:0] rem_diff;
   logic                  in_range;

   // Next-state logic: FSM transitions, ring/sum update and one divider step per cycle
   always_comb begin
      state_d  = state_q;
      ring_d   = ring_q;
      sum_d    = sum_q;
      wptr_d   = wptr_q;
      first_d  = first_q;
      rr_d     = rr_q;
      avg_d    = avg_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      bpm_d    = bpm_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      art_d    = 1'b0;
      rem_sh   = {rem_q, quo_q[15]};
      rem_diff = rem_sh[DATA_WIDTH-1:0] - avg_q;
      in_range = (i_rr_period >= RR_LO) && (i_rr_period <= RR_HI);
      if (i_ce) begin
         if (i_rr_valid && (state_q != IDLE)) begin
            ovr_d = 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (i_rr_valid) begin
                  if (in_range) begin
                     rr_d    = i_rr_period;
                     state_d = ACCUM;
                  end else begin
                     art_d = 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (first_q) begin
                  for (int i = 0; i < N_AVG; i++) begin
                     ring_d[i] = rr_q;
                  end
                  sum_d   = {rr_q, {LOG2N{1'b0}}};
                  first_d = 1'b0;
               end else begin
                  ring_d[wptr_q] = rr_q;
                  sum_d = sum_q - SUM_W'(ring_q[wptr_q]) + SUM_W'(rr_q);
               end
               wptr_d  = wptr_q + LOG2N'(1);
               avg_d   = sum_d[SUM_W-1:LOG2N];
               rem_d   = '0;
               quo_d   = NUMER;
               cnt_d   = 4'd0;
               state_d = DIVIDE;
            end
            DIVIDE: begin
               // Remainder stays below the divisor, so the low bits of the difference are exact
               if (rem_sh >= {1'b0, avg_q}) begin
                  rem_d = rem_diff;
                  quo_d = {quo_q[14:0], 1'b1};
               end else begin
                  rem_d = rem_sh[DATA_WIDTH-1:0];
                  quo_d = {quo_q[14:0], 1'b0};
               end
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = OUTPUT;
               end
            end
            OUTPUT: begin
               if (!valid_q) begin
                  valid_d = 1'b1;
                  bpm_d   = (quo_q[15:8] != 8'd0) ? 8'hFF : quo_q[7:0];
               end else if (i_hr_ready) begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers; the artifact pulse self-clears on every edge
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= IDLE;
         for (int i = 0; i < N_AVG; i++) begin
            ring_q[i] <= '0;
         end
         sum_q   <= '0;
         wptr_q  <= '0;
         first_q <= 1'b1;
         rr_q    <= '0;
         avg_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= 4'd0;
         bpm_q   <= 8'd0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         art_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ring_q  <= ring_d;
         sum_q   <= sum_d;
         wptr_q  <= wptr_d;
         first_q <= first_d;
         rr_q    <= rr_d;
         avg_q   <= avg_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         bpm_q   <= bpm_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         art_q   <= art_d;
      end
   end

`ifdef RR_STATS_MINMAX_EN
   logic [DATA_WIDTH-1:0] min_q, max_q;

   // Track extremes of accepted beats; the first beat after reset loads both
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         min_q <= '0;
         max_q <= '0;
      end else if (i_ce && (state_q == ACCUM)) begin
         if (first_q || (rr_q < min_q)) min_q <= rr_q;
         if (first_q || (rr_q > max_q)) max_q <= rr_q;
      end
   end

   assign o_rr_min = min_q;
   assign o_rr_max = max_q;
`else
   assign o_rr_min = '0;
   assign o_rr_max = '0;
`endif

   assign o_busy     = (state_q != IDLE);
   assign o_rr_avg   = avg_q;
   assign o_hr_bpm   = bpm_q;
   assign o_hr_valid = valid_q;
   assign o_artifact = art_q;
   assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_rr_stats.sv
// Self-checking bench for rr_stats: directed scenarios plus a randomized phase
// (random RR values, random clock-enable gaps, random consumer back-pressure).
module tb_rr_stats;

   localparam int NW  = 8;
   localparam int NUM = 60 * 360;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        ce = 1'b1;
   logic [10:0] rr_period = '0;
   logic        rr_valid = 1'b0;
   logic        hr_ready = 1'b0;
   logic        o_busy, o_hr_valid, o_artifact, o_overrun;
   logic [10:0] o_rr_avg, o_rr_min, o_rr_max;
   logic [7:0]  o_hr_bpm;

   int checks = 0;
   int errors = 0;
   bit rand_ce = 1'b0;

   // reference model state
   int hist[$];
   bit first = 1'b1;
   int exp_avg = 0, exp_bpm = 0, mn = 0, mx = 0;
   bit ovr_exp = 1'b0;

   rr_stats dut (
      .i_clk       (clk),
      .i_nrst      (nrst),
      .i_ce        (ce),
      .i_rr_period (rr_period),
      .i_rr_valid  (rr_valid),
      .o_busy      (o_busy),
      .o_rr_avg    (o_rr_avg),
      .o_hr_bpm    (o_hr_bpm),
      .o_hr_valid  (o_hr_valid),
      .i_hr_ready  (hr_ready),
      .o_artifact  (o_artifact),
      .o_overrun   (o_overrun),
      .o_rr_min    (o_rr_min),
      .o_rr_max    (o_rr_max)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      hist.delete();
      first   = 1'b1;
      exp_avg = 0;
      exp_bpm = 0;
      mn      = 0;
      mx      = 0;
      ovr_exp = 1'b0;
   endfunction

   function automatic void model_accept(input int rr);
      int s;
      if (first) begin
         hist.delete();
         for (int i = 0; i < NW; i++) hist.push_back(rr);
         first = 1'b0;
         mn = rr;
         mx = rr;
      end else begin
         void'(hist.pop_front());
         hist.push_back(rr);
         if (rr < mn) mn = rr;
         if (rr > mx) mx = rr;
      end
      s = 0;
      foreach (hist[i]) s += hist[i];
      exp_avg = s / NW;
      exp_bpm = NUM / exp_avg;
      if (exp_bpm > 255) exp_bpm = 255;
   endfunction

   function automatic int exp_min();
`ifdef RR_STATS_MINMAX_EN
      return mn;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_max();
`ifdef RR_STATS_MINMAX_EN
      return mx;
`else
      return 0;
`endif
   endfunction

   // advance one clock; en reports whether that edge was enabled
   task automatic step(output bit en);
      en = ce;
      @(negedge clk);
      if (rand_ce) ce = ($urandom_range(0, 3) != 0);
      else ce = 1'b1;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      ce = 1'b1;
      rr_valid = 1'b0;
      hr_ready = 1'b0;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      model_reset();
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_busy"}, o_busy, 0);
      chk({pfx, "_valid"}, o_hr_valid, 0);
      chk({pfx, "_avg"}, o_rr_avg, 0);
      chk({pfx, "_bpm"}, o_hr_bpm, 0);
      chk({pfx, "_artifact"}, o_artifact, 0);
      chk({pfx, "_overrun"}, o_overrun, 0);
      chk({pfx, "_min"}, o_rr_min, 0);
      chk({pfx, "_max"}, o_rr_max, 0);
   endtask

   // present one beat; for a legal beat, wait for the result and deliver it
   task automatic send(input int rr, input int hold, input bit inject);
      bit en;
      bit ok;
      int lat;
      int guard;
      ok = (rr >= 72) && (rr <= 720);
      hr_ready = (hold == 0);
      rr_period = 11'(rr);
      rr_valid = 1'b1;
      guard = 0;
      do begin
         step(en);
         guard++;
      end while (!en && guard < 100);
      rr_valid = 1'b0;
      if (!ok) begin
         chk("artifact", o_artifact, 1);
         chk("art_busy", o_busy, 0);
         step(en);
         chk("art_pulse_end", o_artifact, 0);
         chk("art_avg_kept", o_rr_avg, exp_avg);
         chk("art_no_valid", o_hr_valid, 0);
         return;
      end
      model_accept(rr);
      chk("busy", o_busy, 1);
      lat = 0;
      guard = 0;
      while (!o_hr_valid && guard < 300) begin
         step(en);
         if (en) lat++;
         guard++;
      end
      chk("latency", lat, 18);
      chk("rr_avg", o_rr_avg, exp_avg);
      chk("hr_bpm", o_hr_bpm, exp_bpm);
      chk("rr_min", o_rr_min, exp_min());
      chk("rr_max", o_rr_max, exp_max());
      for (int i = 0; i < hold; i++) begin
         rr_valid = inject && (i == 3);
         rr_period = 11'd300;
         step(en);
         if (en && rr_valid) ovr_exp = 1'b1;
         rr_valid = 1'b0;
         chk("hold_valid", o_hr_valid, 1);
         chk("hold_avg", o_rr_avg, exp_avg);
         chk("hold_bpm", o_hr_bpm, exp_bpm);
      end
      hr_ready = 1'b1;
      guard = 0;
      do begin
         step(en);
         guard++;
      end while (!en && guard < 100);
      hr_ready = 1'b0;
      chk("valid_drop", o_hr_valid, 0);
      chk("idle", o_busy, 0);
      chk("overrun", o_overrun, int'(ovr_exp));
   endtask

   initial begin
      bit en;
      bit seen;
      int rr;
      int hold;

      // reset state
      do_reset();
      check_reset_outputs("rst");

      // single beat from reset, then a second beat into the window
      send(360, 0, 0);
      chk("b360_avg", o_rr_avg, 360);
      chk("b360_bpm", o_hr_bpm, 60);
      send(180, 0, 0);
      chk("b180_avg", o_rr_avg, 337);
      chk("b180_bpm", o_hr_bpm, 64);

      // out-of-range beats are rejected and do not disturb the first-beat load
      do_reset();
      send(50, 0, 0);
      send(800, 0, 0);
      send(360, 0, 0);
      chk("after_art_bpm", o_hr_bpm, 60);

      // shortest legal RR saturates the rate
      do_reset();
      send(72, 0, 0);
      chk("sat_bpm", o_hr_bpm, 255);

      // consumer stall with a colliding beat
      do_reset();
      send(360, 0, 0);
      send(240, 10, 1);
      chk("stall_overrun", o_overrun, 1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(en);
         seen |= o_hr_valid;
      end
      chk("single_result", int'(seen), 0);
      chk("stall_idle", o_busy, 0);
      chk("overrun_sticky", o_overrun, 1);

      // reset in the middle of a division
      do_reset();
      send(360, 0, 0);
      rr_period = 11'd480;
      rr_valid = 1'b1;
      step(en);
      rr_valid = 1'b0;
      step(en);
      repeat (8) step(en);
      chk("mid_div_busy", o_busy, 1);
      #2 nrst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      nrst = 1'b1;
      model_reset();
      send(240, 0, 0);
      chk("reload_avg", o_rr_avg, 240);
      chk("reload_bpm", o_hr_bpm, 90);

      // randomized beats with clock-enable gaps and back-pressure
      do_reset();
      rand_ce = 1'b1;
      for (int k = 0; k < 14; k++) begin
         rr = int'($urandom_range(40, 780));
         hold = int'($urandom_range(0, 3));
         send(rr, hold, 1'b0);
      end
      rand_ce = 1'b0;
      ce = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
